// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the 16-bit core bus to 8-bit external memory bridge.
package mem_bus_pkg;

   localparam int unsigned WAIT_W = 4;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   localparam logic LANE_LO = 1'b0;
   localparam logic LANE_HI = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StLo,
      StHi,
      StDone
   } bridge_state_e;

   function automatic logic [15:0] lane_addr(logic [14:0] word_addr, logic lane);
      return {word_addr, lane};
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable down-counter that times one external byte phase.
module mem_wait_timer
   import mem_bus_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WAIT_W-1:0] value,
   output logic              zero
);

   logic [WAIT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - WAIT_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mem_bridge_8b.sv
// Bus target that splits 16-bit core requests into one or two 8-bit external byte cycles.
module mem_bridge_8b
   import mem_bus_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_bus_assert,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_data,
   input  logic        mem_cmd,
   input  logic        be0,
   input  logic        be1,
   output logic        mem_rdy,
   output logic [15:0] mem_rdata,
   output logic [15:0] ext_addr,
   output logic [7:0]  ext_wdata,
   input  logic [7:0]  ext_rdata,
   output logic        ext_ce,
   output logic        ext_we,
   output logic        ext_oe
);

   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

   bridge_state_e state;
   logic [14:0]   word_addr;
   logic [7:0]    wdata_hi;
   logic          be1_q;
   logic          cmd_q;
   logic          timer_load;
   logic          timer_zero;

   // The lane bit of the byte address comes from the phase, never from the request.
   logic unused_addr0;
   assign unused_addr0 = mem_addr[0];

   // Idle keeps the timer primed so a phase entered from idle starts at WAIT_STATES.
   assign timer_load = (state == StIdle) || ((state == StLo) && timer_zero);

   mem_wait_timer u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (timer_load),
      .value (WAIT_LOAD),
      .zero  (timer_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         mem_rdy   <= 1'b0;
         mem_rdata <= '0;
         ext_addr  <= '0;
         ext_wdata <= '0;
         ext_ce    <= 1'b0;
         ext_we    <= 1'b0;
         ext_oe    <= 1'b0;
         word_addr <= '0;
         wdata_hi  <= '0;
         be1_q     <= 1'b0;
         cmd_q     <= CMD_READ;
      end else begin
         mem_rdy <= 1'b0;
         unique case (state)
            StIdle: begin
               if (mem_bus_assert) begin
                  word_addr <= mem_addr[15:1];
                  wdata_hi  <= mem_data[15:8];
                  be1_q     <= be1;
                  cmd_q     <= mem_cmd;
                  if (mem_cmd == CMD_READ) mem_rdata <= '0;
                  if (be0 || be1) begin
                     ext_ce    <= 1'b1;
                     ext_we    <= (mem_cmd == CMD_WRITE);
                     ext_oe    <= (mem_cmd == CMD_READ);
                     ext_addr  <= lane_addr(mem_addr[15:1], be0 ? LANE_LO : LANE_HI);
                     ext_wdata <= be0 ? mem_data[7:0] : mem_data[15:8];
                     state     <= be0 ? StLo : StHi;
                  end else begin
                     state   <= StDone;
                     mem_rdy <= 1'b1;
                  end
               end
            end
            StLo: begin
               if (timer_zero) begin
                  if (cmd_q == CMD_READ) mem_rdata[7:0] <= ext_rdata;
                  if (be1_q) begin
                     // Strobes stay up: the high phase follows with no idle gap.
                     ext_addr  <= lane_addr(word_addr, LANE_HI);
                     ext_wdata <= wdata_hi;
                     state     <= StHi;
                  end else begin
                     ext_ce  <= 1'b0;
                     ext_we  <= 1'b0;
                     ext_oe  <= 1'b0;
                     state   <= StDone;
                     mem_rdy <= 1'b1;
                  end
               end
            end
            StHi: begin
               if (timer_zero) begin
                  if (cmd_q == CMD_READ) mem_rdata[15:8] <= ext_rdata;
                  ext_ce  <= 1'b0;
                  ext_we  <= 1'b0;
                  ext_oe  <= 1'b0;
                  state   <= StDone;
                  mem_rdy <= 1'b1;
               end
            end
            StDone: state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

endmodule
